// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/execute controller for the 4-bit CPU core
module instruction_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        mem_data,
    input  logic              mem_ready,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              pc_hold,
    output logic              jump_enable,
    output logic [ADDR_W-1:0] jump_addr,
    output logic              pc_inc_2,
    output logic [2:0]        alu_op,
    output logic [3:0]        alu_imm,
    output logic              reg_we,
    output logic              z_flag,
    output logic              c_flag,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXECUTE,
        S_UPDATE,
        S_HALTED
    } state_t;

    state_t            state;
    logic [7:0]        ir;
    logic [ADDR_W-1:0] operand;

    logic [3:0] opcode;
    logic       is_alu;
    logic       is_flag_op;
    logic       is_jmp;
    logic       is_jz;
    logic       is_jc;
    logic       is_hlt;
    logic       jump_taken;

    assign opcode     = ir[7:4];
    assign is_alu     = (opcode != 4'h0) && !opcode[3];
    assign is_flag_op = is_alu && (opcode != 4'h1);
    assign is_jmp     = (opcode == 4'h8);
    assign is_jz      = (opcode == 4'h9);
    assign is_jc      = (opcode == 4'hA);
    assign is_hlt     = (opcode == HLT_OPCODE);

    // Flags read here were already written by this instruction's EXECUTE cycle
    assign jump_taken = is_jmp || (is_jz && z_flag) || (is_jc && c_flag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= 8'h00;
            operand <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_hlt)
                        state <= S_HALTED;
                    else if (is_jmp || is_jz || is_jc)
                        state <= S_OPERAND;
                    else
                        state <= S_EXECUTE;
                end
                S_OPERAND: begin
                    if (mem_ready) begin
                        operand <= mem_data[ADDR_W-1:0];
                        state   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_flag_op) begin
                        z_flag <= alu_zero;
                        c_flag <= alu_carry;
                    end
                    state <= S_UPDATE;
                end
                S_UPDATE:  state <= S_FETCH;
                S_HALTED:  state <= S_HALTED;
                default:   state <= S_FETCH;
            endcase
        end
    end

    assign mem_req     = (state == S_FETCH) || (state == S_OPERAND);
    assign mem_addr    = (state == S_OPERAND) ? pc + ADDR_W'(1) : pc;
    assign pc_hold     = (state != S_UPDATE);
    assign jump_enable = (state == S_UPDATE) && jump_taken;
    assign jump_addr   = operand;
    assign pc_inc_2    = (state == S_UPDATE) && !jump_taken && (is_jz || is_jc);
    assign reg_we      = (state == S_EXECUTE) && is_alu;
    assign alu_op      = reg_we ? ir[6:4] : 3'd0;
    assign alu_imm     = ir[3:0];
    assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed bench for instruction_sequencer
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_init = 8'h00;
    logic [7:0] mem_data;
    logic       mem_ready = 1'b1;
    logic       alu_zero = 1'b0;
    logic       alu_carry = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       pc_hold;
    logic       jump_enable;
    logic [7:0] jump_addr;
    logic       pc_inc_2;
    logic [2:0] alu_op;
    logic [3:0] alu_imm;
    logic       reg_we;
    logic       z_flag;
    logic       c_flag;
    logic       halted;

    logic [7:0] mem [256];
    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    assign mem_data = mem_ready ? mem[mem_addr] : 8'hEE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= pc_init;
        else if (!pc_hold)
            pc <= jump_enable ? jump_addr : (pc_inc_2 ? pc + 8'd2 : pc + 8'd1);
    end

    instruction_sequencer #(.ADDR_W(8), .HLT_OPCODE(4'hF)) dut (
        .clk(clk), .reset(reset), .pc(pc), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_req(mem_req), .mem_addr(mem_addr),
        .pc_hold(pc_hold), .jump_enable(jump_enable), .jump_addr(jump_addr),
        .pc_inc_2(pc_inc_2), .alu_op(alu_op), .alu_imm(alu_imm), .reg_we(reg_we),
        .z_flag(z_flag), .c_flag(c_flag), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Resets with the given start PC; returns on a falling edge with the DUT in FETCH
    task automatic do_reset(input logic [7:0] start_pc);
        pc_init = start_pc;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ctl", {mem_req, pc_hold, jump_enable, pc_inc_2, reg_we, halted, z_flag, c_flag},
              8'b1100_0000);
        check("rst_addr", mem_addr, start_pc);
        check("rst_jaddr_op", {jump_addr, 1'b0, alu_op}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_update(output int cycles);
        cycles = 0;
        while (pc_hold && cycles < 20) begin
            step();
            cycles++;
        end
        check("reach_update", pc_hold, 1'b0);
    endtask

    initial begin
        // LDI 5: flags must not follow the ALU
        clear_mem();
        mem[0] = 8'h15;
        alu_zero = 1'b1; alu_carry = 1'b1;
        do_reset(8'h00);
        check("ldi_fetch", {mem_req, mem_addr}, {1'b1, 8'h00});
        step();
        check("ldi_decode", {mem_req, pc_hold, reg_we}, 3'b010);
        step();
        check("ldi_exec", {reg_we, alu_op, alu_imm}, {1'b1, 3'd1, 4'd5});
        step();
        check("ldi_update", {pc_hold, jump_enable, pc_inc_2}, 3'b000);
        step();
        check("ldi_next", {mem_req, mem_addr}, {1'b1, 8'h01});
        check("ldi_flags", {z_flag, c_flag}, 2'b00);

        // JMP 3C
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h3C;
        do_reset(8'h00);
        step();
        step();
        check("jmp_operand", {mem_req, mem_addr}, {1'b1, 8'h01});
        step();
        check("jmp_exec", {reg_we, alu_op}, 4'h0);
        step();
        check("jmp_update", {jump_enable, pc_inc_2, jump_addr}, {2'b10, 8'h3C});
        step();
        check("jmp_target", mem_addr, 8'h3C);

        // SUB with zero, then JZ 20 taken
        clear_mem();
        mem[0] = 8'h31; mem[1] = 8'h90; mem[2] = 8'h20;
        alu_zero = 1'b1; alu_carry = 1'b0;
        do_reset(8'h00);
        wait_update(n);
        check("sub_cycles", n + 1, 4);
        check("sub_zflag", {z_flag, c_flag}, 2'b10);
        step();
        wait_update(n);
        check("jz_cycles", n + 1, 5);
        check("jz_taken", {jump_enable, pc_inc_2, jump_addr}, {2'b10, 8'h20});
        step();
        check("jz_target", mem_addr, 8'h20);

        // Same program, zero clear: JZ falls through by two
        alu_zero = 1'b0;
        do_reset(8'h00);
        wait_update(n);
        check("sub2_zflag", z_flag, 1'b0);
        step();
        wait_update(n);
        check("jz_untaken", {jump_enable, pc_inc_2}, 2'b01);
        step();
        check("jz_fall", mem_addr, 8'h03);

        // Memory stalls three cycles in FETCH
        clear_mem();
        mem[0] = 8'h25;
        mem_ready = 1'b0;
        do_reset(8'h00);
        for (int i = 0; i < 3; i++) begin
            check("stall_fetch", {mem_req, pc_hold, alu_imm, mem_addr}, {2'b11, 4'h0, 8'h00});
            step();
        end
        mem_ready = 1'b1;
        wait_update(n);
        check("stall_cycles", 3 + n + 1, 7);

        // JC at pc=FF with carry clear: operand address wraps
        clear_mem();
        mem[8'hFF] = 8'hA0; mem[0] = 8'h77;
        do_reset(8'hFF);
        check("jc_fetch", mem_addr, 8'hFF);
        step();
        step();
        check("jc_operand_wrap", {mem_req, mem_addr}, {1'b1, 8'h00});
        step();
        step();
        check("jc_untaken", {pc_hold, jump_enable, pc_inc_2}, 3'b001);
        step();
        check("jc_next", mem_addr, 8'h01);

        // HLT stays halted
        clear_mem();
        mem[0] = 8'hF0;
        do_reset(8'h00);
        for (int i = 0; i < 12; i++) step();
        check("hlt_state", {halted, pc_hold, mem_req, jump_enable, pc_inc_2}, 5'b11000);
        check("hlt_pc", mem_addr, 8'h00);

        // Reset in the middle of an ADD's EXECUTE cycle
        clear_mem();
        mem[0] = 8'h21; mem[1] = 8'h22;
        alu_zero = 1'b1; alu_carry = 1'b1;
        do_reset(8'h00);
        wait_update(n);
        check("add_flags", {z_flag, c_flag}, 2'b11);
        step();
        step();
        step();
        check("add2_exec", {reg_we, alu_op, alu_imm}, {1'b1, 3'd2, 4'd2});
        #2 reset = 1'b1;
        #1;
        check("abort_ctl", {reg_we, z_flag, c_flag, pc_hold, jump_enable, pc_inc_2, mem_req},
              7'b0001001);
        check("abort_ir", {alu_imm, alu_op}, 7'h00);
        step();
        reset = 1'b0;
        check("abort_fetch", {mem_req, mem_addr}, {1'b1, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 4-bit CPU core.
- Fetches 1- or 2-byte instructions from instruction memory at the current PC and drives ALU/register-file control.
- Sequences the program counter through its hold, jump, +1 and +2 controls, advancing it exactly once per instruction.
- Owns the Z/C flag registers used for conditional jumps.

Parameters:
- ADDR_W, 8, width of PC, memory address, and jump target.
- HLT_OPCODE, 4'hF, opcode that enters the permanent HALTED state.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces FETCH and clears all registers
- pc  input  ADDR_W  current program counter value
- mem_data  input  8  instruction memory read data; valid when mem_ready=1
- mem_ready  input  1  memory read complete for the current mem_addr
- alu_zero  input  1  ALU zero result; sampled in EXECUTE
- alu_carry  input  1  ALU carry/borrow result; sampled in EXECUTE
- mem_req  output  1  read request, high in FETCH and OPERAND
- mem_addr  output  ADDR_W  pc in FETCH, pc+1 (mod 2^ADDR_W) in OPERAND, else pc
- pc_hold  output  1  drives the PC halt input; 0 only in UPDATE
- jump_enable  output  1  PC load strobe
- jump_addr  output  ADDR_W  PC load target (operand register)
- pc_inc_2  output  1  PC +2 strobe
- alu_op  output  3  ir[6:4] in EXECUTE for opcodes 1–7, else 0
- alu_imm  output  4  ir[3:0]
- reg_we  output  1  accumulator write enable, one cycle
- z_flag  output  1  registered zero flag
- c_flag  output  1  registered carry flag
- halted  output  1  high in HALTED

Behaviour:
- Registers:
  - state: FETCH, DECODE, OPERAND, EXECUTE, UPDATE, HALTED.
  - ir[7:0], operand[ADDR_W-1:0], z_flag, c_flag.
  - All reset to FETCH and 0.
- Outputs are Moore functions of state and the registers.
- Values while reset is asserted: mem_req=1, mem_addr=pc, pc_hold=1, jump_enable=0, jump_addr=0, pc_inc_2=0, alu_op=0, reg_we=0, halted=0.
- Opcode map (ir[7:4]):
  - 0 NOP.
  - 1–7 ALU ops: LDI, ADD, SUB, AND, OR, XOR, NOT. alu_op=ir[6:4], imm=ir[3:0].
  - 8 JMP, 9 JZ, A JC: 2-byte; the second byte is the target.
  - F HLT.
  - B–E: treated as NOP.
- FETCH: mem_req=1, mem_addr=pc. Stays in FETCH while mem_ready=0. On mem_ready=1, ir<=mem_data and go to DECODE.
- DECODE: one cycle. Opcodes 8–A go to OPERAND; HLT goes to HALTED; all others go to EXECUTE.
- OPERAND: mem_req=1, mem_addr=pc+1 (wraps: pc=FF gives addr 00). Waits for mem_ready. On mem_ready=1, operand<=mem_data and go to EXECUTE.
- EXECUTE: one cycle.
  - Opcodes 1–7: reg_we=1, alu_op driven.
  - Opcodes 2–7: z_flag<=alu_zero and c_flag<=alu_carry at the clock edge. LDI does not change the flags.
  - Go to UPDATE.
- UPDATE: one cycle, pc_hold=0, then back to FETCH.
  - jump_enable=1 if JMP, or JZ with z_flag=1, or JC with c_flag=1. jump_addr=operand.
  - Else pc_inc_2=1 for an untaken JZ/JC.
  - Else plain +1 (all strobes 0).
  - jump_enable and pc_inc_2 are never high together.
- HALTED: pc_hold=1, halted=1, mem_req=0. Exits only via reset.
- PC invariant: pc_hold=1 in every state except UPDATE, so the PC changes exactly once per instruction.
- Flags are evaluated in UPDATE, after the EXECUTE update of the same instruction. A conditional jump therefore sees flags from the most recent ALU instruction.
- Latency with mem_ready always 1:
  - 1-byte instruction: 4 cycles (FETCH, DECODE, EXECUTE, UPDATE).
  - 2-byte instruction: 5 cycles.
  - Each cycle of mem_ready=0 adds one cycle.
- mem_data is ignored when mem_ready=0.
- Reset asserted mid-instruction aborts it: no PC strobe, no reg_we; flags and ir are cleared.

Test Plan:
- Reset, then mem_ready=1 with memory [00]=0x15 (LDI 5) -> FETCH, DECODE, EXECUTE (reg_we=1, alu_op=1, alu_imm=5), then UPDATE with pc_hold=0 and no strobes. Next FETCH at pc=01; 4 cycles total.
- [00]=0x80, [01]=0x3C (JMP 3C) -> OPERAND shows mem_addr=01. UPDATE has jump_enable=1, jump_addr=3C; next fetch at 3C; 5 cycles.
- SUB with alu_zero=1, then JZ 0x20 -> z_flag=1 and jump_enable=1 to 20. Repeat with alu_zero=0 -> pc_inc_2=1, jump_enable=0.
- mem_ready held low for 3 cycles in FETCH -> state stays FETCH, pc_hold=1, ir unchanged; instruction completes in 7 cycles.
- pc=FF, opcode JC with c_flag=0 -> mem_addr=00 in OPERAND; pc_inc_2=1 in UPDATE.
- HLT (0xF0) -> halted=1 and pc_hold=1 indefinitely. Separately, assert reset during EXECUTE of ADD -> immediately FETCH, reg_we=0, flags=0, no PC strobe.
